// File: rtl/c_drain.sv
// Drains C-buffer entries as a stream of ACC_W-bit lanes, most-significant lane first.
// Each word is read (1 cycle), waited on (1 cycle), then sent as four handshaked beats.
module c_drain #(
  parameter int unsigned IDX_W = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_W-1:0]     num_words,
  output logic                 busy,
  output logic                 done,
  output logic                 C_wr_en,
  output logic [IDX_W-1:0]     C_index,
  output logic [4*ACC_W-1:0]   C_data_in,
  input  logic [4*ACC_W-1:0]   C_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_last
);

  localparam int unsigned CW = 4 * ACC_W;
  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   num_q;
  logic [IDX_W-1:0]   word_q;
  logic [IDX_W-1:0]   c_index_q;
  logic [1:0]         lane_q;
  logic [CW-1:0]      hold_q;
  logic               busy_q;
  logic               done_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_data_q;
  logic               out_last_q;

  logic               last_word;
  logic [1:0]         lane_nxt;
  logic [ACC_W-1:0]   lane_data;

  // num_q is never zero while a word is in flight, so num_q - 1 cannot wrap here.
  assign last_word = (word_q == (num_q - IdxOne));
  assign lane_nxt  = lane_q + 2'd1;

  always_comb begin
    lane_data = hold_q[CW-1 -: ACC_W];
    case (lane_nxt)
      2'd1:    lane_data = hold_q[3*ACC_W-1 -: ACC_W];
      2'd2:    lane_data = hold_q[2*ACC_W-1 -: ACC_W];
      2'd3:    lane_data = hold_q[ACC_W-1:0];
      default: lane_data = hold_q[CW-1 -: ACC_W];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_q       <= '0;
      word_q      <= '0;
      c_index_q   <= '0;
      lane_q      <= '0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_q  <= num_words;
            word_q <= '0;
            if (num_words == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // Address goes out on entry so it is presented throughout READ.
              state_q   <= StRead;
              busy_q    <= 1'b1;
              c_index_q <= '0;
            end
          end
        end
        StRead: begin
          state_q <= StWait;
        end
        StWait: begin
          hold_q      <= C_data_out;
          lane_q      <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= C_data_out[CW-1 -: ACC_W];
          out_last_q  <= 1'b0;
          state_q     <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            if (lane_q == 2'd3) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (last_word) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                word_q    <= word_q + IdxOne;
                c_index_q <= word_q + IdxOne;
                state_q   <= StRead;
              end
            end else begin
              lane_q     <= lane_nxt;
              out_data_q <= lane_data;
              out_last_q <= last_word && (lane_q == 2'd2);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign C_wr_en   = 1'b0;
  assign C_data_in = '0;
  assign C_index   = c_index_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_c_drain.sv
// Scoreboard bench for c_drain: expected beats are queued at start and popped on handshakes.
module tb_c_drain;

  localparam int IDX_W = 16;
  localparam int ACC_W = 32;
  localparam int CW    = 4 * ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] num_words = '0;
  logic             busy, done, C_wr_en, out_valid, out_last;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] C_index;
  logic [CW-1:0]    C_data_in;
  logic [CW-1:0]    c_rd = '0;
  logic [ACC_W-1:0] out_data;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t         sb[$];
  logic [CW-1:0] mem[0:15];
  int            vecs = 0;
  int            errs = 0;

  c_drain #(.IDX_W(IDX_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .C_wr_en   (C_wr_en),
    .C_index   (C_index),
    .C_data_in (C_data_in),
    .C_data_out(c_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read C buffer: data valid one cycle after the address.
  always @(posedge clk) c_rd <= mem[C_index[3:0]];

  task automatic push_word(input int idx, input bit last_word);
    beat_t b;
    for (int l = 0; l < 4; l++) begin
      b.data = mem[idx][(3 - l) * ACC_W +: ACC_W];
      b.last = last_word && (l == 3);
      sb.push_back(b);
    end
  endtask

  // Returns at the falling edge of the first cycle after start is accepted.
  task automatic start_drain(input int n);
    @(negedge clk);
    start     = 1'b1;
    num_words = n[IDX_W-1:0];
    for (int w = 0; w < n; w++) push_word(w, w == n - 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vecs++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, out_valid, out_last});
    end
    vecs++;
    if (out_data !== '0 || C_index !== '0) begin
      errs++;
      $display("FAIL reset_data: got data %h idx %h expected 0 0", out_data, C_index);
    end
    vecs++;
    if (C_wr_en !== 1'b0 || C_data_in !== '0) begin
      errs++;
      $display("FAIL reset_wr: got %b %h expected 0 0", C_wr_en, C_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int    done_cyc;
    beat_t b;
    done_cyc  = -1;
    out_ready = 1'b1;
    start_drain(2);
    for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
      vecs++;
      if (busy !== (cyc <= 12)) begin
        errs++;
        $display("FAIL basic_busy cyc %0d: got %b expected %b", cyc, busy, cyc <= 12);
      end
      vecs++;
      if (C_wr_en !== 1'b0 || C_data_in !== '0) begin
        errs++;
        $display("FAIL basic_wr cyc %0d: got %b %h expected 0 0", cyc, C_wr_en, C_data_in);
      end
      if (out_valid && out_ready) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL basic_extra_beat: got %h expected none", out_data);
        end else begin
          b = sb.pop_front();
          if ({out_data, out_last} !== {b.data, b.last}) begin
            errs++;
            $display("FAIL basic_beat: got %h/%b expected %h/%b", out_data, out_last,
                     b.data, b.last);
          end
        end
      end
      if (done === 1'b1) done_cyc = cyc;
      @(negedge clk);
    end
    vecs++;
    if (done_cyc != 13) begin
      errs++;
      $display("FAIL basic_done_latency: got %0d expected 13", done_cyc);
    end
    vecs++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL basic_lost_beats: got %0d left expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_stall();
    int               done_cyc;
    logic             prev_v, prev_r;
    logic [ACC_W-1:0] prev_d;
    beat_t            b;
    done_cyc  = -1;
    prev_v    = 1'b0;
    prev_r    = 1'b0;
    prev_d    = '0;
    out_ready = 1'b0;
    start_drain(1);
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      out_ready = ~out_ready;
      if (prev_v && !prev_r) begin
        vecs++;
        if (out_valid !== 1'b1 || out_data !== prev_d) begin
          errs++;
          $display("FAIL stall_hold cyc %0d: got %b/%h expected 1/%h", cyc, out_valid,
                   out_data, prev_d);
        end
      end
      if (out_valid && out_ready) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL stall_extra_beat: got %h expected none", out_data);
        end else begin
          b = sb.pop_front();
          if ({out_data, out_last} !== {b.data, b.last}) begin
            errs++;
            $display("FAIL stall_beat: got %h/%b expected %h/%b", out_data, out_last,
                     b.data, b.last);
          end
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      if (done === 1'b1) done_cyc = cyc;
      @(negedge clk);
    end
    out_ready = 1'b1;
    vecs++;
    if (done_cyc != 10) begin
      errs++;
      $display("FAIL stall_done_latency: got %0d expected 10", done_cyc);
    end
    vecs++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL stall_lost_beats: got %0d left expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    start_drain(0);
    vecs++;
    if ({done, busy, out_valid} !== 3'b100) begin
      errs++;
      $display("FAIL zero_done: got done/busy/valid %b expected 100", {done, busy, out_valid});
    end
    for (int cyc = 2; cyc <= 4; cyc++) begin
      @(negedge clk);
      vecs++;
      if ({done, busy, out_valid} !== 3'b000) begin
        errs++;
        $display("FAIL zero_idle cyc %0d: got %b expected 000", cyc, {done, busy, out_valid});
      end
    end
  endtask

  task automatic test_ignore_start();
    int    done_cyc;
    beat_t b;
    done_cyc  = -1;
    out_ready = 1'b1;
    start_drain(2);
    for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
      if (cyc == 3) begin
        start     = 1'b1;
        num_words = 16'd9;
      end else if (cyc == 4) begin
        start = 1'b0;
      end
      vecs++;
      if (C_index > 16'd1) begin
        errs++;
        $display("FAIL ignore_index cyc %0d: got %0d expected <= 1", cyc, C_index);
      end
      if (out_valid && out_ready) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL ignore_extra_beat: got %h expected none", out_data);
        end else begin
          b = sb.pop_front();
          if ({out_data, out_last} !== {b.data, b.last}) begin
            errs++;
            $display("FAIL ignore_beat: got %h/%b expected %h/%b", out_data, out_last,
                     b.data, b.last);
          end
        end
      end
      if (done === 1'b1) done_cyc = cyc;
      @(negedge clk);
    end
    vecs++;
    if (done_cyc != 13) begin
      errs++;
      $display("FAIL ignore_done_latency: got %0d expected 13", done_cyc);
    end
    vecs++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL ignore_lost_beats: got %0d left expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    bit hit;
    beats     = 0;
    hit       = 1'b0;
    out_ready = 1'b1;
    start_drain(2);
    for (int cyc = 1; cyc <= 20 && !hit; cyc++) begin
      if (beats == 2 && out_valid === 1'b1) begin
        hit   = 1'b1;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({out_valid, out_last, busy, done} !== 4'b0000) begin
          errs++;
          $display("FAIL midreset_flags: got %b expected 0000",
                   {out_valid, out_last, busy, done});
        end
        vecs++;
        if (out_data !== '0 || C_index !== '0) begin
          errs++;
          $display("FAIL midreset_data: got %h idx %h expected 0 0", out_data, C_index);
        end
      end else begin
        if (out_valid && out_ready) beats++;
        @(negedge clk);
      end
    end
    vecs++;
    if (!hit) begin
      errs++;
      $display("FAIL midreset_reach_lane2: got beats %0d expected 2 then valid", beats);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({out_valid, busy} !== 2'b00) begin
      errs++;
      $display("FAIL midreset_no_resume: got %b expected 00", {out_valid, busy});
    end
    test_basic();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {4{32'hdead0000 + 32'(i)}};
    mem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[1] = {32'd8, 32'd7, 32'd6, 32'd5};
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
